serial_subtractor_4bit: RTL and testbench

SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

---
 rtl/serial_subtractor_4bit.sv | 134 +++++++++++++
 tb/tb_serial_subtractor_4bit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first.
// Optional macro SUB_OVF_DETECT_EN adds the signed-overflow output Ovf.
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVF_DETECT_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic             bit_d;
  logic             br_next;
  logic             last_bit;

`ifdef SUB_OVF_DETECT_EN
  logic a_msb;
  logic b_msb;
`endif

  always_comb begin
    bit_d    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    last_bit = (bit_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The minuend register doubles as the result register: each difference
  // bit enters at the MSB as the consumed operand bit leaves at the LSB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh    <= '0;
      b_sh    <= '0;
      br      <= 1'b0;
      bit_cnt <= '0;
      Diff    <= '0;
      Bout    <= 1'b0;
`ifdef SUB_OVF_DETECT_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      Ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_sh    <= A;
            b_sh    <= B;
            br      <= Bin;
            bit_cnt <= '0;
`ifdef SUB_OVF_DETECT_EN
            a_msb   <= A[WIDTH-1];
            b_msb   <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh    <= {bit_d, a_sh[WIDTH-1:1]};
          b_sh    <= b_sh >> 1;
          br      <= br_next;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            Diff <= {bit_d, a_sh[WIDTH-1:1]};
            Bout <= br_next;
`ifdef SUB_OVF_DETECT_EN
            Ovf  <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Scoreboard bench for serial_subtractor_4bit: driver pushes model results,
// a negedge monitor pops and compares whenever Done is presented.
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Diff;
  logic         Bout;
`ifdef SUB_OVF_DETECT_EN
  logic         Ovf;
`endif

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           done_cycle;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           cycle = 0;
  int           check_cnt = 0;
  int           pass_cnt = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .Start(Start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .Busy (Busy),
    .Done (Done),
    .Diff (Diff),
    .Bout (Bout)
`ifdef SUB_OVF_DETECT_EN
    ,
    .Ovf  (Ovf)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, input int done_cycle);
    exp_t r;
    int   d;
    d            = int'(a) - int'(b) - int'(bin);
    r.diff       = d[W-1:0];
    r.bout       = (d < 0);
    r.ovf        = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
    r.done_cycle = done_cycle;
    return r;
  endfunction

  task automatic waitIdle();
    int n = 0;
    while ((Busy || Done) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      check_cnt++;
      $display("[TB] FAIL idle_wait: got Busy/Done still high after %0d cycles, expected idle", n);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin, input bit expect_done);
    waitIdle();
    A     = a;
    B     = b;
    Bin   = bin;
    Start = 1'b1;
    if (expect_done) sb.push_back(model(a, b, bin, cycle + 1 + W));
    @(negedge CLK);
    Start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Bin   = 1'($urandom);
  endtask

  task automatic runHeld(input int n_ops);
    waitIdle();
    Start = 1'b1;
    for (int k = 0; k < n_ops; k++) begin
      A   = W'($urandom);
      B   = W'($urandom);
      Bin = 1'($urandom);
      sb.push_back(model(A, B, Bin, cycle + 1 + W));
      @(negedge CLK);
      for (int j = 0; j < W + 1; j++) begin
        A   = W'($urandom);
        B   = W'($urandom);
        Bin = 1'($urandom);
        @(negedge CLK);
      end
    end
    Start = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (Done) begin
      if (sb.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_done: got Done=1 at cycle %0d, expected no pending result", cycle);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("diff", Diff, mon_e.diff);
        checkOutput("bout", Bout, mon_e.bout);
        checkOutput("done_cycle", cycle, mon_e.done_cycle);
        checkOutput("busy_at_done", Busy, 0);
`ifdef SUB_OVF_DETECT_EN
        checkOutput("ovf", Ovf, mon_e.ovf);
`endif
        last_diff = mon_e.diff;
        last_bout = mon_e.bout;
      end
    end else if (Busy) begin
      checkOutput("hold_diff", Diff, last_diff);
      checkOutput("hold_bout", Bout, last_bout);
    end
  end

  initial begin
    int n;
    RST   = 1'b1;
    Start = 1'b1;
    A     = 4'h7;
    B     = 4'h3;
    Bin   = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      checkOutput("reset_busy", Busy, 0);
      checkOutput("reset_done", Done, 0);
      checkOutput("reset_diff", Diff, 0);
      checkOutput("reset_bout", Bout, 0);
`ifdef SUB_OVF_DETECT_EN
      checkOutput("reset_ovf", Ovf, 0);
`endif
    end

    // Start held across reset release is taken on the first non-reset edge
    RST = 1'b0;
    sb.push_back(model(A, B, Bin, cycle + 1 + W));
    @(negedge CLK);
    Start = 1'b0;

    applyStimulus(4'h2, 4'h3, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b1);
    applyStimulus(4'h0, 4'hF, 1'b1, 1'b1);
    applyStimulus(4'h9, 4'h9, 1'b0, 1'b1);
    applyStimulus(4'h7, 4'hF, 1'b0, 1'b1);
    applyStimulus(4'h5, 4'h2, 1'b0, 1'b1);
    applyStimulus(4'hF, 4'h0, 1'b0, 1'b1);
    applyStimulus(4'h8, 4'h1, 1'b0, 1'b1);

    // Start pulse during RUN must be ignored
    applyStimulus(4'hC, 4'h5, 1'b1, 1'b1);
    @(negedge CLK);
    Start = 1'b1;
    A     = 4'h3;
    B     = 4'h9;
    @(negedge CLK);
    Start = 1'b0;

    // Reset two edges into RUN aborts the request
    applyStimulus(4'hA, 4'h3, 1'b0, 1'b0);
    @(negedge CLK);
    RST   = 1'b1;
    Start = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    Start = 1'b0;
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_done", Done, 0);
    checkOutput("abort_diff", Diff, 0);
    checkOutput("abort_bout", Bout, 0);
    last_diff = '0;
    last_bout = 1'b0;
    repeat (10) @(negedge CLK);
    applyStimulus(4'h6, 4'hB, 1'b0, 1'b1);

    runHeld(6);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          applyStimulus(W'(a), W'(b), 1'(c), 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("scoreboard_empty", sb.size(), 0);
    repeat (4) @(negedge CLK);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
